rsa_modexp_arbiter: RTL

- Shares one Mod_Exp engine between two requesters, e.g. the encrypt and decrypt paths of the RSA ASIP.
- Grants requesters round-robin and latches their operands.
- Starts the engine with a one-cycle reset pulse, waits for its finish, and returns the result on a per-requester valid/ready response channel.
- A watchdog aborts hung computations. Modulo 0 is rejected without launching the engine.

---
 rtl/rsa_modexp_arbiter_if.sv | 28 ++
 rtl/rsa_modexp_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/rsa_modexp_arbiter_if.sv
// rsa_modexp_arbiter_if: requester, response and engine signals of the Mod_Exp arbiter
// slave  = arbiter side: takes req*/rsp*_ready/me_finish/me_result, drives req*_ready, rsp*, me_*, busy
// master = environment side (requesters plus engine), the mirror image
interface rsa_modexp_arbiter_if #(parameter int W = 32);
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_base, req0_exponent, req0_modulo;
  logic [W-1:0] req1_base, req1_exponent, req1_modulo;
  logic         rsp0_valid, rsp0_ready, rsp0_error, rsp1_valid, rsp1_ready, rsp1_error;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic [W-1:0] me_base, me_exponent, me_modulo, me_result;
  logic         me_reset, me_finish, busy;
  modport slave (
    input  req0_valid, req0_base, req0_exponent, req0_modulo,
    input  req1_valid, req1_base, req1_exponent, req1_modulo,
    input  rsp0_ready, rsp1_ready, me_finish, me_result,
    output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_error,
    output rsp1_valid, rsp1_result, rsp1_error,
    output me_base, me_exponent, me_modulo, me_reset, busy
  );
  modport master (
    output req0_valid, req0_base, req0_exponent, req0_modulo,
    output req1_valid, req1_base, req1_exponent, req1_modulo,
    output rsp0_ready, rsp1_ready, me_finish, me_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_error,
    input  rsp1_valid, rsp1_result, rsp1_error,
    input  me_base, me_exponent, me_modulo, me_reset, busy
  );
endinterface

// File: rtl/rsa_modexp_arbiter.sv
// rsa_modexp_arbiter: round-robin sharing of one Mod_Exp engine between two requesters
// clk/reset: clock and async active-high reset; bus: requests, responses, engine control
module rsa_modexp_arbiter #(
  parameter int ARQ            = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  reset,
  rsa_modexp_arbiter_if.slave  bus
);
  localparam int W   = 2 * ARQ;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;
  state_t         r_state;
  logic           r_last, r_owner, r_arm, r_me_reset;
  logic [WDW-1:0] r_wd;
  logic [W-1:0]   r_base, r_exp, r_mod;
  logic [1:0]     r_rsp_valid, r_rsp_error;
  logic [W-1:0]   r_rsp_result [2];
  logic           w_idle, w_grant, w_accept, w_done, w_timeout, w_handshake;
  logic [W-1:0]   w_base, w_exp, w_mod;
  assign w_idle      = r_state == IDLE;
  // on a tie the requester not served last wins; otherwise whoever is valid
  assign w_grant     = bus.req0_valid && bus.req1_valid ? ~r_last : bus.req1_valid;
  assign w_accept    = w_idle && (bus.req0_valid || bus.req1_valid);
  assign w_base      = w_grant ? bus.req1_base : bus.req0_base;
  assign w_exp       = w_grant ? bus.req1_exponent : bus.req0_exponent;
  assign w_mod       = w_grant ? bus.req1_modulo : bus.req0_modulo;
  // finish only counts once it has been seen low in this job, so a stale one is ignored
  assign w_done      = bus.me_finish && r_arm;
  assign w_timeout   = r_wd >= WDW'(TIMEOUT_CYCLES - 1);
  assign w_handshake = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_last          <= 1'b1;
      r_owner         <= 1'b0;
      r_arm           <= 1'b0;
      r_me_reset      <= 1'b1;
      r_wd            <= '0;
      r_base          <= '0;
      r_exp           <= '0;
      r_mod           <= '0;
      r_rsp_valid     <= '0;
      r_rsp_error     <= '0;
      r_rsp_result[0] <= '0;
      r_rsp_result[1] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_me_reset <= 1'b0;
          if (w_accept) begin
            r_base  <= w_base;
            r_exp   <= w_exp;
            r_mod   <= w_mod;
            r_owner <= w_grant;
            r_last  <= w_grant;
            if (w_mod == '0) begin
              r_state               <= RESPOND;
              r_rsp_valid[w_grant]  <= 1'b1;
              r_rsp_error[w_grant]  <= 1'b1;
              r_rsp_result[w_grant] <= '0;
            end else begin
              r_state    <= LAUNCH;
              r_me_reset <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          r_me_reset <= 1'b0;
          r_arm      <= 1'b0;
          r_wd       <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          r_wd <= &r_wd ? r_wd : r_wd + 1'b1;
          if (!bus.me_finish) r_arm <= 1'b1;
          if (w_done || w_timeout) begin
            r_state               <= RESPOND;
            r_rsp_valid[r_owner]  <= 1'b1;
            r_rsp_error[r_owner]  <= !w_done;
            r_rsp_result[r_owner] <= w_done ? bus.me_result : '0;
          end
        end
        RESPOND: begin
          if (w_handshake) begin
            r_state         <= IDLE;
            r_rsp_valid     <= '0;
            r_rsp_error     <= '0;
            r_rsp_result[0] <= '0;
            r_rsp_result[1] <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req0_ready  = w_idle && bus.req0_valid && !w_grant;
  assign bus.req1_ready  = w_idle && bus.req1_valid && w_grant;
  assign bus.rsp0_valid  = r_rsp_valid[0];
  assign bus.rsp1_valid  = r_rsp_valid[1];
  assign bus.rsp0_error  = r_rsp_error[0];
  assign bus.rsp1_error  = r_rsp_error[1];
  assign bus.rsp0_result = r_rsp_result[0];
  assign bus.rsp1_result = r_rsp_result[1];
  assign bus.me_base     = r_base;
  assign bus.me_exponent = r_exp;
  assign bus.me_modulo   = r_mod;
  assign bus.me_reset    = r_me_reset;
  assign bus.busy        = !w_idle;
endmodule
